// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: freeze/flush/bubble/stall controls for the 5-stage core.
// Handles RAW interlocks, EXE branch squash and multi-cycle memory waits.
module pipeline_hazard_controller #(
  parameter int MEM_WAIT_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken_exe,
  input  logic [3:0]  src1_id,
  input  logic [3:0]  src2_id,
  input  logic        uses_src1,
  input  logic        uses_src2,
  input  logic        exe_wb_en,
  input  logic [3:0]  exe_dest,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_req,
  output logic        freeze,
  output logic        bubble_id,
  output logic        flush,
  output logic        stall_all,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MEM_DONE
  } state_t;

  localparam bit LP_MEM_EN = (MEM_WAIT_CYCLES > 0);
  localparam bit LP_ONE    = (MEM_WAIT_CYCLES == 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_stall_cnt;

  logic w_hz1;
  logic w_hz2;
  logic w_hazard;
  logic w_mem_stall;
  logic w_sel_mem;
  logic w_sel_br;
  logic w_sel_hz;

  assign w_hz1 = uses_src1 &
    ((exe_wb_en & (src1_id == exe_dest)) |
     (mem_wb_en & (src1_id == mem_dest)));
  assign w_hz2 = uses_src2 &
    ((exe_wb_en & (src2_id == exe_dest)) |
     (mem_wb_en & (src2_id == mem_dest)));
  assign w_hazard = w_hz1 | w_hz2;

  assign w_mem_stall =
    ((r_state == RUN) & mem_req & LP_MEM_EN) |
    (r_state == MEM_WAIT);

  // Mutually exclusive selects encode the priority order.
  assign w_sel_mem = rst & w_mem_stall;
  assign w_sel_br  = rst & ~w_mem_stall & branch_taken_exe;
  assign w_sel_hz  = rst & ~w_mem_stall & ~branch_taken_exe
                     & w_hazard;

  always_comb begin
    freeze    = 1'b0;
    bubble_id = 1'b0;
    flush     = 1'b0;
    stall_all = 1'b0;
    unique case (1'b1)
      w_sel_mem: begin
        stall_all = 1'b1;
        freeze    = 1'b1;
      end
      w_sel_br: begin
        flush     = 1'b1;
        bubble_id = 1'b1;
      end
      w_sel_hz: begin
        freeze    = 1'b1;
        bubble_id = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (mem_req && LP_MEM_EN) begin
            if (LP_ONE) begin
              r_state <= MEM_DONE;
            end else begin
              r_state <= MEM_WAIT;
              r_cnt   <= CNT_W'(MEM_WAIT_CYCLES - 1);
            end
          end
        end
        MEM_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= MEM_DONE;
          end
        end
        MEM_DONE: r_state <= RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  // Saturating count of frozen cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (freeze && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule
